// File: rtl/rs_pkg.sv
// ----------------------------------------------------------------------------
// rs_pkg
// Shared constants, types and GF(2^8) helpers for the RS(255,239) syndrome
// stage. Field: GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
//   GF_POLY    : low byte of the primitive polynomial (x^8 term implicit)
//   NSYM       : number of syndromes (matches the 128-bit downstream bus)
//   SYM_W      : symbol width in bits
//   alpha_pow  : alpha^k, intended for elaboration-time constants
//   gf_mul     : general GF(2^8) multiply, for reference models
// ----------------------------------------------------------------------------
package rs_pkg;

    localparam logic [7:0]  GF_POLY = 8'h1D;
    localparam int unsigned NSYM    = 16;
    localparam int unsigned SYM_W   = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPend = 2'd1,
        StFire = 2'd2
    } out_state_e;

    // Multiply by alpha (x) with reduction modulo the primitive polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] alpha_pow(input int unsigned k);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < (k % 255); i++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf256_mul_const.sv
// ----------------------------------------------------------------------------
// gf256_mul_const
// Combinational multiply of a GF(2^8) symbol by the constant alpha^K.
// Implemented as a fixed XOR network: each input bit selects one column.
//   i_sym  in  8 : multiplicand
//   o_prod out 8 : i_sym * alpha^K
// ----------------------------------------------------------------------------
module gf256_mul_const
    import rs_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  logic [SYM_W-1:0] i_sym,
    output logic [SYM_W-1:0] o_prod
);

    // Column i is alpha^(K+i), i.e. the product of basis element x^i and alpha^K.
    function automatic logic [SYM_W*SYM_W-1:0] build_cols(input int unsigned k);
        logic [SYM_W*SYM_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            c[SYM_W*i +: SYM_W] = alpha_pow(k + i);
        end
        return c;
    endfunction

    localparam logic [SYM_W*SYM_W-1:0] COLS = build_cols(K);

    always_comb begin
        o_prod = '0;
        for (int i = 0; i < SYM_W; i++) begin
            o_prod = o_prod ^ ({SYM_W{i_sym[i]}} & COLS[SYM_W*i +: SYM_W]);
        end
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// ----------------------------------------------------------------------------
// rs_syndrome_calc
// Streaming syndrome calculator for RS(255,239) over GF(2^8). Symbols arrive
// highest-degree first; 16 Horner accumulators evaluate r(alpha^(j+FCR)).
// Completed syndromes are held in a result register and handed downstream as
// a single-cycle pulse once the downstream stage is not busy.
//   clk         in    1 : clock, rising edge
//   rst         in    1 : asynchronous active-high reset
//   in_sym      in    8 : received symbol
//   in_valid    in    1 : in_sym valid
//   in_sop      in    1 : first symbol of a codeword (qualifies in_valid)
//   in_ready    out   1 : symbol accepted when in_valid && in_ready
//   dn_busy     in    1 : downstream stage busy
//   synd_out    out 128 : S_j in bits [8j+7:8j]
//   synd_valid  out   1 : one-cycle pulse, synd_out valid
//   synd_zero   out   1 : all syndromes zero, valid with synd_valid
//   sop_err     out   1 : one-cycle pulse, codeword truncated by early in_sop
// ----------------------------------------------------------------------------
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int unsigned N   = 255,
    parameter int unsigned FCR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SYM_W-1:0]      in_sym,
    input  logic                  in_valid,
    input  logic                  in_sop,
    output logic                  in_ready,
    input  logic                  dn_busy,
    output logic [NSYM*SYM_W-1:0] synd_out,
    output logic                  synd_valid,
    output logic                  synd_zero,
    output logic                  sop_err
);

    localparam logic [7:0] CNT_LAST = 8'(N - 1);

    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_d;
    logic [SYM_W-1:0]      r_acc   [NSYM];
    logic [SYM_W-1:0]      w_mul   [NSYM];
    logic [SYM_W-1:0]      w_acc_d [NSYM];
    logic [NSYM*SYM_W-1:0] r_res;
    logic [NSYM*SYM_W-1:0] w_res_d;
    logic                  r_zero;
    logic                  r_sop_err;
    out_state_e            r_state;
    out_state_e            w_state_d;

    logic w_accept;
    logic w_first;
    logic w_last;
    logic w_early_sop;
    logic w_pend;
    logic w_cnt_last;

    // ------------------------------------------------------------------
    // Handshake and symbol classification
    // ------------------------------------------------------------------
    assign w_pend      = (r_state != StIdle);
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    // Only a completing symbol stalls, so an unsent result is never overwritten.
    assign in_ready    = !(w_pend && w_cnt_last);
    assign w_accept    = in_valid && in_ready;
    assign w_first     = (r_cnt == 8'd0) || in_sop;
    assign w_early_sop = w_accept && in_sop && (r_cnt != 8'd0);
    // An sop symbol always starts a codeword, so it can never complete one (N >= 2).
    assign w_last      = w_accept && !in_sop && w_cnt_last;

    // ------------------------------------------------------------------
    // Horner update: acc <- acc * alpha^(j+FCR) ^ sym, or restart on first
    // ------------------------------------------------------------------
    for (genvar j = 0; j < NSYM; j++) begin : g_synd
        gf256_mul_const #(
            .K(j + FCR)
        ) u_mul (
            .i_sym  (r_acc[j]),
            .o_prod (w_mul[j])
        );

        assign w_acc_d[j]                 = w_first ? in_sym : (w_mul[j] ^ in_sym);
        assign w_res_d[SYM_W*j +: SYM_W]  = w_acc_d[j];
    end

    always_comb begin
        w_cnt_d = r_cnt;
        if (w_accept) begin
            if (in_sop) begin
                // The sop symbol is symbol 0 of the new codeword.
                w_cnt_d = 8'd1;
            end else if (w_cnt_last) begin
                w_cnt_d = 8'd0;
            end else begin
                w_cnt_d = r_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: IDLE -> (PEND while busy) -> FIRE (one cycle) -> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_last) w_state_d = dn_busy ? StPend : StFire;
            end
            StPend: begin
                if (!dn_busy) w_state_d = StFire;
            end
            StFire: begin
                // No completion can land here: in_ready holds the last symbol off.
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_res     <= '0;
            r_zero    <= 1'b0;
            r_sop_err <= 1'b0;
            r_state   <= StIdle;
            for (int j = 0; j < NSYM; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            r_cnt     <= w_cnt_d;
            r_state   <= w_state_d;
            r_sop_err <= w_early_sop;
            if (w_accept) begin
                for (int j = 0; j < NSYM; j++) begin
                    r_acc[j] <= w_acc_d[j];
                end
            end
            if (w_last) begin
                r_res  <= w_res_d;
                r_zero <= ~|w_res_d;
            end
        end
    end

    assign synd_out   = r_res;
    assign synd_zero  = r_zero;
    assign synd_valid = (r_state == StFire);
    assign sop_err    = r_sop_err;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// ----------------------------------------------------------------------------
// tb_rs_syndrome_calc
// Self-checking bench for rs_syndrome_calc: directed cases plus randomized
// codewords, compared against a direct polynomial-evaluation model.
// ----------------------------------------------------------------------------
module tb_rs_syndrome_calc;

    localparam int N  = 255;
    localparam int NS = 16;

    typedef logic [7:0] cw_t [N];

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_sym;
    logic         in_valid;
    logic         in_sop;
    logic         in_ready;
    logic         dn_busy;
    logic [127:0] synd_out;
    logic         synd_valid;
    logic         synd_zero;
    logic         sop_err;

    rs_syndrome_calc #(
        .N   (N),
        .FCR (0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_sym     (in_sym),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_ready   (in_ready),
        .dn_busy    (dn_busy),
        .synd_out   (synd_out),
        .synd_valid (synd_valid),
        .synd_zero  (synd_zero),
        .sop_err    (sop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: S_j = sum_i r_i * alpha^(j * deg_i), deg_i = N-1-i
    // ------------------------------------------------------------------
    logic [7:0] exp_tab [255];

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_synd(input cw_t cw);
        logic [127:0] v;
        logic [7:0]   s;
        v = '0;
        for (int j = 0; j < NS; j++) begin
            s = 8'h00;
            for (int i = 0; i < N; i++) begin
                s = s ^ tb_mul(cw[i], exp_tab[(j * (N - 1 - i)) % 255]);
            end
            v[8*j +: 8] = s;
        end
        return v;
    endfunction

    logic [127:0] exp_q [$];
    int           sop_err_seen = 0;
    int           exp_sop_err  = 0;
    logic         prev_valid   = 1'b0;
    logic         busy_edge    = 1'b0;
    logic         rand_busy    = 1'b0;

    // ------------------------------------------------------------------
    // Output monitor: every pulse is matched in order against the model
    // ------------------------------------------------------------------
    always @(posedge clk) busy_edge <= dn_busy;

    always @(negedge clk) begin
        logic [127:0] e;
        if (!rst) begin
            if (synd_valid) begin
                check("pulse_width", {127'd0, prev_valid}, 128'd0);
                check("busy_gate", {127'd0, busy_edge}, 128'd0);
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {127'd0, synd_valid}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("synd_out", synd_out, e);
                    check("synd_zero", {127'd0, synd_zero}, {127'd0, (e == 128'd0)});
                end
            end
            if (sop_err) sop_err_seen++;
        end
        prev_valid = synd_valid;
    end

    always @(negedge clk) begin
        if (rand_busy) dn_busy = ($urandom_range(0, 2) == 0);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_sym(input logic [7:0] s, input logic sop, output int stalls);
        @(negedge clk);
        in_valid = 1'b1;
        in_sym   = s;
        in_sop   = sop;
        stalls   = 0;
        while (!in_ready && stalls < 3000) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 3000) check("ready_timeout", {127'd0, in_ready}, 128'd1);
    endtask

    task automatic send_cw(input cw_t cw, output int last_stalls);
        int st;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) exp_q.push_back(ref_synd(cw));
            drive_sym(cw[i], (i == 0), st);
        end
        last_stalls = st;
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    function automatic cw_t make_cw(input int kind);
        cw_t c;
        for (int i = 0; i < N; i++) c[i] = (kind == 2) ? 8'($urandom) : 8'h00;
        if (kind == 1) c[$urandom_range(0, N - 1)] = 8'($urandom_range(1, 255));
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    localparam logic [127:0] VEC_DEG0 = {16{8'h01}};
    localparam logic [127:0] VEC_DEG1 = 128'h2613_87CD_E874_3A1D_8040_2010_0804_0201;

    initial begin
        cw_t cw;
        int  st;
        int  sop_before;

        exp_tab[0] = 8'h01;
        for (int k = 1; k < 255; k++) exp_tab[k] = tb_mul(exp_tab[k-1], 8'h02);

        rst = 1'b1; in_valid = 1'b0; in_sym = 8'h00; in_sop = 1'b0; dn_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_synd_out", synd_out, 128'd0);
        check("rst_synd_valid", {127'd0, synd_valid}, 128'd0);
        check("rst_synd_zero", {127'd0, synd_zero}, 128'd0);
        check("rst_sop_err", {127'd0, sop_err}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        rst = 1'b0;

        // All-zero codeword, result the cycle after the last symbol
        cw = make_cw(0);
        send_cw(cw, st);
        go_idle();
        check("t1_latency", {127'd0, synd_valid}, 128'd1);
        check("t1_out", synd_out, 128'd0);
        check("t1_zero", {127'd0, synd_zero}, 128'd1);

        // Error at degree 0
        cw = make_cw(0);
        cw[N-1] = 8'h01;
        send_cw(cw, st);
        go_idle();
        check("t2_latency", {127'd0, synd_valid}, 128'd1);
        check("t2_out", synd_out, VEC_DEG0);
        check("t2_zero", {127'd0, synd_zero}, 128'd0);

        // Error at degree 1
        cw = make_cw(0);
        cw[N-2] = 8'h01;
        send_cw(cw, st);
        go_idle();
        check("t3_out", synd_out, VEC_DEG1);

        // Reset mid-codeword: partial data must leave no trace
        for (int i = 0; i < 50; i++) drive_sym(8'($urandom_range(1, 255)), (i == 0), st);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_sop = 1'b0;
        @(negedge clk);
        check("t6_rst_out", synd_out, 128'd0);
        check("t6_rst_valid", {127'd0, synd_valid}, 128'd0);
        check("t6_rst_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;
        cw = make_cw(0);
        cw[N-1] = 8'h01;
        send_cw(cw, st);
        go_idle();
        check("t6_out", synd_out, VEC_DEG0);

        // Back-to-back codewords with dn_busy held high
        @(negedge clk);
        dn_busy = 1'b1;
        fork
            begin
                cw = make_cw(0);
                cw[N-1] = 8'h01;
                send_cw(cw, st);
                cw = make_cw(0);
                send_cw(cw, st);
                check("b2b_stall", {127'd0, (st > 0)}, 128'd1);
                go_idle();
            end
            begin
                repeat (400) @(negedge clk);
                check("b2b_hold", synd_out, VEC_DEG0);
                repeat (200) @(negedge clk);
                dn_busy = 1'b0;
            end
        join
        wait_drain();

        // Early in_sop at symbol 100, then a clean codeword
        sop_before = sop_err_seen;
        for (int i = 0; i < 100; i++) drive_sym(8'($urandom), (i == 0), st);
        exp_sop_err++;
        cw = make_cw(0);
        send_cw(cw, st);
        go_idle();
        check("t5_out", synd_out, 128'd0);
        wait_drain();
        check("t5_sop_err", 128'(sop_err_seen - sop_before), 128'd1);

        // Randomized codewords with random backpressure and truncations
        rand_busy = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int plen;
                plen = $urandom_range(1, N - 1);
                for (int i = 0; i < plen; i++) drive_sym(8'($urandom), (i == 0), st);
                exp_sop_err++;
            end
            cw = make_cw($urandom_range(0, 2));
            send_cw(cw, st);
        end
        go_idle();
        rand_busy = 1'b0;
        @(negedge clk);
        dn_busy = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("sop_err_total", 128'(sop_err_seen), 128'(exp_sop_err));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
